uart_rx: RTL and testbench
==========================

# uart_rx

Standalone UART receiver that pairs with the existing UART transmitter. It takes the asynchronous `serial_in` line, synchronizes it, oversamples each bit by `CLOCKS_PER_BIT`, and deserializes one frame: start bit, data LSB-first, optional parity bit, stop bit. Each frame ends in a one-cycle valid or error pulse. It sits on the receive side of the UART top and can also be used alone for external serial links.

## Interface
- `INPUT_DATA_WIDTH`, 8: data bits per frame.
- `PARITY_ENABLED`, 1: 1 = a parity bit follows the data; 0 = no parity bit.
- `PARITY_TYPE`, 0: 0 = even parity, 1 = odd parity.
- `CLOCKS_PER_BIT`, 8: clk cycles per bit; even, ≥4.
- `NUMBER_OF_RX_SYNCHRONIZERS`, 3: flip-flop stages on `serial_in`.
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `serial_in`  in  1  asynchronous serial line; idles high.
- `received_data`  out  `INPUT_DATA_WIDTH`  last good frame; holds between frames.
- `data_is_valid`  out  1  one-cycle pulse: new `received_data`.
- `rx_error`  out  1  one-cycle pulse: parity or framing error.
- `break_detected`  out  1  level; see Configuration.

## Operation
- Reset values:
  - all synchronizer stages = 1.
  - state = IDLE.
  - `received_data` = 0, `data_is_valid` = 0, `rx_error` = 0, `break_detected` = 0.
  - bit and clock counters = 0.
- States: IDLE, START_BIT, DATA_BIT, PARITY_BIT, STOP_BIT, WAIT_IDLE. The bit index counts 0..`INPUT_DATA_WIDTH`-1 inside DATA_BIT.
- IDLE: when the synchronized line is low, go to START_BIT and clear the clock counter.
- START_BIT: after `CLOCKS_PER_BIT`/2 clocks, sample the line.
  - Low: go to DATA_BIT and restart the counter.
  - High: glitch; return to IDLE with no pulse.
- DATA_BIT: sample every `CLOCKS_PER_BIT` clocks into a shift register, LSB first. After the last bit, go to PARITY_BIT if `PARITY_ENABLED`, else STOP_BIT.
- PARITY_BIT: sample and store the parity bit.
  - Parity ok means XOR of data and parity bit == `PARITY_TYPE`.
- STOP_BIT sample, stop high:
  - parity ok (or no parity): `received_data` <= shift register, `data_is_valid` = 1 for one cycle.
  - parity bad: `rx_error` = 1 for one cycle; `received_data` unchanged.
  - Then go to IDLE.
- STOP_BIT sample, stop low: framing error. `rx_error` = 1 for one cycle, go to WAIT_IDLE.
- WAIT_IDLE: stay until the synchronized line is high, then go to IDLE. This prevents a low line from being taken as a new start.
- `data_is_valid` and `rx_error` are never high in the same cycle.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is discarded and produces no pulse.

## Timing
- Edge 0 = first rising clk edge that samples `serial_in` low.
- Synchronized low is visible to the FSM after edge `NUMBER_OF_RX_SYNCHRONIZERS`-1; START_BIT is entered at edge `NUMBER_OF_RX_SYNCHRONIZERS`.
- Start sample at edge S = `NUMBER_OF_RX_SYNCHRONIZERS` + `CLOCKS_PER_BIT`/2.
- Bit k sample (k = 1 first data bit … stop bit) at edge S + k·`CLOCKS_PER_BIT`.
- The `data_is_valid`/`rx_error` pulse is registered at the stop-sample edge. It is high in cycle L = S + (`INPUT_DATA_WIDTH` + `PARITY_ENABLED` + 1)·`CLOCKS_PER_BIT`; with defaults L = 87.
- Back-to-back frames: a start edge arriving one bit time after the stop-sample midpoint is accepted. IDLE is re-entered at the stop-sample edge.
- Counter widths: `$clog2(CLOCKS_PER_BIT)` and `$clog2(INPUT_DATA_WIDTH)`; both wrap-free (explicit clear).

## Configuration
- `UART_RX_BREAK_DETECT_EN` defined: a break is all data bits 0, the parity bit 0 if present, and stop 0.
  - On a break, `break_detected` goes high at the stop-sample edge together with the `rx_error` pulse.
  - It stays high through WAIT_IDLE and clears on the edge the FSM leaves WAIT_IDLE.
- Not defined: `break_detected` is tied 0 and its logic is omitted; framing errors behave as above.

## Structure
- Shared package `uart_pkg`:
  - RX state encoding localparams.
  - default `CLOCKS_PER_BIT` and `NUMBER_OF_RX_SYNCHRONIZERS`.
  - a parity function `uart_parity(data, type)` reused by the transmitter.
- One sub-module, `rx_synchronizer`: an N-stage flip-flop chain with asynchronous reset to 1, parameterized by `NUMBER_OF_RX_SYNCHRONIZERS`.

## Test plan
- Defaults, frame 0xA5 with even parity bit 0 and stop 1 → `data_is_valid` high only in cycle 87, `received_data` = 0xA5, `rx_error` 0.
- Frame 0x01 sent with parity bit 0 (wrong for even) → `rx_error` pulse in cycle 87, `data_is_valid` 0, `received_data` keeps its prior value.
- `serial_in` low for 2 clocks, then high → no state change beyond START_BIT, no pulse, back in IDLE.
- Frame 0x3C with stop bit 0, line then high → `rx_error` pulse at 87; the next frame 0xC3 is received correctly.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two `data_is_valid` pulses 80 cycles apart with the correct data.
- Reset asserted at cycle 40 of a frame → outputs 0 immediately, no pulse. With `UART_RX_BREAK_DETECT_EN` defined, line held low for 12 bit times → `rx_error` pulse and `break_detected` = 1 until 3 cycles after the line returns high.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receiver and transmitter:
//   - RX state encodings and the RX state enum
//   - default bit period and synchronizer depth
//   - uart_parity(): parity bit for a data word (even or odd)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DEFAULT_CLOCKS_PER_BIT             = 8;
    localparam int DEFAULT_NUMBER_OF_RX_SYNCHRONIZERS = 3;

    localparam logic [2:0] RX_IDLE_ENC       = 3'd0;
    localparam logic [2:0] RX_START_BIT_ENC  = 3'd1;
    localparam logic [2:0] RX_DATA_BIT_ENC   = 3'd2;
    localparam logic [2:0] RX_PARITY_BIT_ENC = 3'd3;
    localparam logic [2:0] RX_STOP_BIT_ENC   = 3'd4;
    localparam logic [2:0] RX_WAIT_IDLE_ENC  = 3'd5;

    typedef enum logic [2:0] {
        IDLE       = RX_IDLE_ENC,
        START_BIT  = RX_START_BIT_ENC,
        DATA_BIT   = RX_DATA_BIT_ENC,
        PARITY_BIT = RX_PARITY_BIT_ENC,
        STOP_BIT   = RX_STOP_BIT_ENC,
        WAIT_IDLE  = RX_WAIT_IDLE_ENC
    } rx_state_t;

    // Parity bit that makes XOR(data, parity) equal parity_type
    // (0 = even, 1 = odd). Narrower words are zero-extended by the caller,
    // which does not change the XOR.
    function automatic logic uart_parity(input logic [63:0] data, input logic parity_type);
        return (^data) ^ parity_type;
    endfunction

endpackage

// File: rtl/rx_synchronizer.sv
// -----------------------------------------------------------------------------
// rx_synchronizer
// N-stage flip-flop chain bringing the asynchronous serial line into the clk
// domain. All stages reset to 1 so a reset never looks like a start bit.
// Ports:
//   clk      in  clock
//   reset    in  asynchronous active-high reset
//   async_i  in  asynchronous input
//   sync_o   out synchronized output (last stage)
// NUMBER_OF_RX_SYNCHRONIZERS must be >= 2.
// -----------------------------------------------------------------------------
module rx_synchronizer #(
    parameter int NUMBER_OF_RX_SYNCHRONIZERS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic [NUMBER_OF_RX_SYNCHRONIZERS-1:0] sync_q;

    // Shift chain, stage 0 samples the raw line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[NUMBER_OF_RX_SYNCHRONIZERS-2:0], async_i};
        end
    end

    assign sync_o = sync_q[NUMBER_OF_RX_SYNCHRONIZERS-1];

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: synchronizes serial_in, oversamples each bit CLOCKS_PER_BIT
// times, sampling mid-bit, and deserializes start / data (LSB first) /
// optional parity / stop. Each frame ends in a one-cycle data_is_valid pulse
// (good frame) or rx_error pulse (parity or framing error).
// Ports:
//   clk             in  clock
//   reset           in  asynchronous active-high reset
//   serial_in       in  asynchronous serial line, idles high
//   received_data   out last good frame, held between frames
//   data_is_valid   out one-cycle pulse, new received_data
//   rx_error        out one-cycle pulse, parity or framing error
//   break_detected  out level, break seen (only with UART_RX_BREAK_DETECT_EN)
// Optional feature: define UART_RX_BREAK_DETECT_EN to enable break detection;
// otherwise break_detected is tied low.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH           = 8,
    parameter int PARITY_ENABLED             = 1,
    parameter int PARITY_TYPE                = 0,
    parameter int CLOCKS_PER_BIT             = DEFAULT_CLOCKS_PER_BIT,
    parameter int NUMBER_OF_RX_SYNCHRONIZERS = DEFAULT_NUMBER_OF_RX_SYNCHRONIZERS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        serial_in,
    output logic [INPUT_DATA_WIDTH-1:0] received_data,
    output logic                        data_is_valid,
    output logic                        rx_error,
    output logic                        break_detected
);

    localparam int CW = (CLOCKS_PER_BIT   > 2) ? $clog2(CLOCKS_PER_BIT)   : 1;
    localparam int BW = (INPUT_DATA_WIDTH > 2) ? $clog2(INPUT_DATA_WIDTH) : 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(INPUT_DATA_WIDTH - 1);

    logic                        rx_sync_s;
    logic                        parity_ok_s;

    rx_state_t                   state_q,         state_d;
    logic [CW-1:0]               clk_cnt_q,       clk_cnt_d;
    logic [BW-1:0]               bit_idx_q,       bit_idx_d;
    logic [INPUT_DATA_WIDTH-1:0] shift_q,         shift_d;
    logic                        parity_q,        parity_d;
    logic [INPUT_DATA_WIDTH-1:0] received_data_q, received_data_d;
    logic                        valid_q,         valid_d;
    logic                        error_q,         error_d;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                        break_q,         break_d;
`endif

    rx_synchronizer #(
        .NUMBER_OF_RX_SYNCHRONIZERS(NUMBER_OF_RX_SYNCHRONIZERS)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .async_i(serial_in),
        .sync_o (rx_sync_s)
    );

    // Without a parity bit every frame counts as parity-ok
    assign parity_ok_s = (PARITY_ENABLED == 0) ||
                         (parity_q == uart_parity(64'(shift_q), 1'(PARITY_TYPE)));

    // Frame FSM: next state, counters, shift register and output pulses
    always_comb begin
        state_d         = state_q;
        clk_cnt_d       = clk_cnt_q;
        bit_idx_d       = bit_idx_q;
        shift_d         = shift_q;
        parity_d        = parity_q;
        received_data_d = received_data_q;
        valid_d         = 1'b0;
        error_d         = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        break_d         = break_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_sync_s) begin
                    state_d   = START_BIT;
                    clk_cnt_d = '0;
                end else begin
                    state_d   = IDLE;
                end
            end
            START_BIT: begin
                // Half a bit in: mid-point of the start bit
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    if (!rx_sync_s) begin
                        state_d   = DATA_BIT;
                        bit_idx_d = '0;
                    end else begin
                        state_d   = IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            DATA_BIT: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    // LSB arrives first, so shift in from the top
                    shift_d   = {rx_sync_s, shift_q[INPUT_DATA_WIDTH-1:1]};
                    if (bit_idx_q == IDX_LAST) begin
                        bit_idx_d = '0;
                        if (PARITY_ENABLED != 0) begin
                            state_d = PARITY_BIT;
                        end else begin
                            state_d = STOP_BIT;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            PARITY_BIT: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    parity_d  = rx_sync_s;
                    state_d   = STOP_BIT;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            STOP_BIT: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_sync_s) begin
                        state_d = IDLE;
                        if (parity_ok_s) begin
                            received_data_d = shift_q;
                            valid_d         = 1'b1;
                        end else begin
                            error_d         = 1'b1;
                        end
                    end else begin
                        // Framing error: wait for the line to rise before
                        // looking for another start bit
                        state_d = WAIT_IDLE;
                        error_d = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                        break_d = (shift_q == '0) &&
                                  ((PARITY_ENABLED == 0) || !parity_q);
`endif
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            WAIT_IDLE: begin
                if (rx_sync_s) begin
                    state_d = IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
                    break_d = 1'b0;
`endif
                end else begin
                    state_d = WAIT_IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                clk_cnt_d = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            clk_cnt_q       <= '0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            parity_q        <= 1'b0;
            received_data_q <= '0;
            valid_q         <= 1'b0;
            error_q         <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            break_q         <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            clk_cnt_q       <= clk_cnt_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            parity_q        <= parity_d;
            received_data_q <= received_data_d;
            valid_q         <= valid_d;
            error_q         <= error_d;
`ifdef UART_RX_BREAK_DETECT_EN
            break_q         <= break_d;
`endif
        end
    end

    assign received_data = received_data_q;
    assign data_is_valid = valid_q;
    assign rx_error      = error_q;
`ifdef UART_RX_BREAK_DETECT_EN
    assign break_detected = break_q;
`else
    assign break_detected = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx. The main instance uses the defaults (8 data
// bits, even parity, 8 clocks/bit, 3 synchronizers); a second instance without
// parity carries the back-to-back frames. Cycle numbers are counted from
// edge 0, the first rising edge that samples the start bit.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_in;
    logic       serial_np;
    logic [7:0] rd,    rd_np;
    logic       dv,    dv_np;
    logic       re,    re_np;
    logic       bd,    bd_np;

    always #5 clk = ~clk;

    uart_rx #(
        .INPUT_DATA_WIDTH(8), .PARITY_ENABLED(1), .PARITY_TYPE(0),
        .CLOCKS_PER_BIT(8), .NUMBER_OF_RX_SYNCHRONIZERS(3)
    ) dut (
        .clk(clk), .reset(reset), .serial_in(serial_in),
        .received_data(rd), .data_is_valid(dv), .rx_error(re), .break_detected(bd)
    );

    uart_rx #(
        .INPUT_DATA_WIDTH(8), .PARITY_ENABLED(0), .PARITY_TYPE(0),
        .CLOCKS_PER_BIT(8), .NUMBER_OF_RX_SYNCHRONIZERS(3)
    ) dut_np (
        .clk(clk), .reset(reset), .serial_in(serial_np),
        .received_data(rd_np), .data_is_valid(dv_np), .rx_error(re_np), .break_detected(bd_np)
    );

    int checks = 0;
    int errors = 0;

    // Pulse record of the most recent run
    int         v_cnt, e_cnt, v_cyc0, v_cyc1, e_cyc0, brk_first, brk_last;
    int         both_total = 0;
    logic [7:0] v_dat0, v_dat1;
    logic [63:0] line;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rec();
        v_cnt = 0; e_cnt = 0; v_cyc0 = -1; v_cyc1 = -1; e_cyc0 = -1;
        brk_first = -1; brk_last = -1; v_dat0 = 8'h00; v_dat1 = 8'h00;
    endtask

    task automatic record(input int e, input logic v, input logic er,
                          input logic b, input logic [7:0] d);
        if (v) begin
            if (v_cnt == 0) begin v_cyc0 = e; v_dat0 = d; end
            else if (v_cnt == 1) begin v_cyc1 = e; v_dat1 = d; end
            v_cnt++;
        end
        if (er) begin
            if (e_cnt == 0) e_cyc0 = e;
            e_cnt++;
        end
        if (v && er) both_total++;
        if (b) begin
            if (brk_first < 0) brk_first = e;
            brk_last = e;
        end
    endtask

    // Drive 'bits' (bit 0 first, one bit time each) for ncyc clocks and
    // record the pulses seen on the selected instance.
    task automatic run_line(input logic [63:0] bits, input int ncyc, input bit np);
        int idx;
        logic lv;
        clear_rec();
        for (int e = 0; e < ncyc; e++) begin
            idx = e / CPB;
            lv  = (idx < 64) ? bits[idx] : 1'b1;
            if (np) serial_np = lv; else serial_in = lv;
            @(posedge clk); #1;
            if (np) record(e, dv_np, re_np, bd_np, rd_np);
            else    record(e, dv, re, bd, rd);
        end
    endtask

    initial begin
        reset     = 1'b1;
        serial_in = 1'b1;
        serial_np = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data",  {56'h0, rd}, 64'h0);
        check("reset_valid", {63'h0, dv}, 64'h0);
        check("reset_error", {63'h0, re}, 64'h0);
        check("reset_break", {63'h0, bd}, 64'h0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // 0xA5, even parity 0, stop 1
        line = '1; line[10:0] = {1'b1, 1'b0, 8'hA5, 1'b0};
        run_line(line, 110, 1'b0);
        check("a5_valid_cnt", v_cnt, 1);
        check("a5_valid_cyc", v_cyc0, 87);
        check("a5_data",      {56'h0, v_dat0}, 64'hA5);
        check("a5_err_cnt",   e_cnt, 0);

        // 0x01 with parity 0 (wrong for even)
        line = '1; line[10:0] = {1'b1, 1'b0, 8'h01, 1'b0};
        run_line(line, 110, 1'b0);
        check("par_err_cnt",   e_cnt, 1);
        check("par_err_cyc",   e_cyc0, 87);
        check("par_valid_cnt", v_cnt, 0);
        check("par_data_hold", {56'h0, rd}, 64'hA5);

        // Glitch: line low for 2 clocks only
        clear_rec();
        for (int e = 0; e < 40; e++) begin
            serial_in = (e < 2) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            record(e, dv, re, bd, rd);
        end
        check("glitch_pulses", v_cnt + e_cnt, 0);
        check("glitch_data",   {56'h0, rd}, 64'hA5);

        // 0x3C with stop 0, then line high
        line = '1; line[10:0] = {1'b0, 1'b0, 8'h3C, 1'b0};
        run_line(line, 120, 1'b0);
        check("frm_err_cnt",   e_cnt, 1);
        check("frm_err_cyc",   e_cyc0, 87);
        check("frm_valid_cnt", v_cnt, 0);
        check("frm_no_break",  brk_first, -1);

        // 0xC3 (even parity 0) received after the framing error
        line = '1; line[10:0] = {1'b1, 1'b0, 8'hC3, 1'b0};
        run_line(line, 110, 1'b0);
        check("c3_valid_cyc", v_cyc0, 87);
        check("c3_data",      {56'h0, rd}, 64'hC3);
        check("c3_err_cnt",   e_cnt, 0);

        // Back-to-back 0x00 then 0xFF, no parity, no gap
        line = '1;
        line[9:0]   = {1'b1, 8'h00, 1'b0};
        line[19:10] = {1'b1, 8'hFF, 1'b0};
        run_line(line, 180, 1'b1);
        check("b2b_valid_cnt", v_cnt, 2);
        check("b2b_cyc0",      v_cyc0, 79);
        check("b2b_spacing",   v_cyc1 - v_cyc0, 80);
        check("b2b_data0",     {56'h0, v_dat0}, 64'h00);
        check("b2b_data1",     {56'h0, v_dat1}, 64'hFF);
        check("b2b_err_cnt",   e_cnt, 0);

        // Reset asserted at cycle 40 of a 0x5A frame
        line = '1; line[10:0] = {1'b1, 1'b0, 8'h5A, 1'b0};
        clear_rec();
        for (int e = 0; e < 140; e++) begin
            serial_in = line[e / CPB];
            @(posedge clk); #1;
            if (e == 40) begin
                reset = 1'b1;
                #1;
                check("rstmid_data",  {56'h0, rd}, 64'h0);
                check("rstmid_valid", {63'h0, dv}, 64'h0);
                check("rstmid_error", {63'h0, re}, 64'h0);
            end
            if (e == 100) reset = 1'b0;
            record(e, dv, re, bd, rd);
        end
        check("rstmid_pulses", v_cnt + e_cnt, 0);
        check("rstmid_data_after", {56'h0, rd}, 64'h0);

`ifdef UART_RX_BREAK_DETECT_EN
        // Line low for 12 bit times
        line = '1; line[11:0] = 12'h000;
        run_line(line, 130, 1'b0);
        check("brk_err_cnt",   e_cnt, 1);
        check("brk_err_cyc",   e_cyc0, 87);
        check("brk_valid_cnt", v_cnt, 0);
        check("brk_first",     brk_first, 87);
        check("brk_last",      brk_last, 98);
`endif

        check("valid_error_exclusive", both_total, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
